sobel_result_writer: RTL and testbench
======================================

// Module: sobel_result_writer
// PURPOSE
//  Downstream stage of the Sobel datapath. Captures each per-pixel result (Gradient, Dop, Out_Row,
//  Out_Column) when the window loader flags isReady. Buffers results in a FIFO and emits
//  address/data write beats to the output frame memory over a valid/ready handshake.
//  Signals frame completion once the last pixel (isEnd) has been written out.
// PARAMETERS
//  IMG_W   64  image width in pixels; used for the address computation
//  DEPTH   16  FIFO entries; power of 2, >= 2
//  ADDR_W  12  output address width
// PORTS
//  Clk        in   1       rising-edge clock
//  Reset      in   1       asynchronous, active-high reset
//  InValid    in   1       result valid this cycle (driven from isReady)
//  InEnd      in   1       last pixel of frame (driven from isEnd)
//  InGrad     in   8       gradient magnitude (Gradient)
//  InDop      in   1       edge bit after threshold T (Dop)
//  InRow      in   8       pixel row (Out_Row)
//  InCol      in   8       pixel column (Out_Column)
//  Clear      in   1       synchronous; DONE -> IDLE, clears Overflow
//  OutValid   out  1       write beat valid
//  OutReady   in   1       memory accepts beat
//  OutAddr    out  ADDR_W  write address
//  OutData    out  8       write data
//  Overflow   out  1       sticky: a sample was dropped
//  FrameDone  out  1       high while in DONE
// BEHAVIOUR
//  - Reset: FSM=IDLE; FIFO empty; OutValid=0, OutAddr=0, OutData=0, Overflow=0, FrameDone=0.
//  - FSM states and transitions:
//    - IDLE -> RUN on the first InValid; that sample is accepted.
//    - RUN -> FLUSH on a cycle with InEnd=1. The sample is included if InValid=1.
//    - FLUSH -> DONE when the FIFO is empty and no beat is pending.
//    - DONE -> IDLE on Clear.
//    - InValid is ignored in FLUSH and DONE. Clear is ignored in other states.
//  - Accept: push when InValid && (IDLE|RUN).
//    - Entry = {addr, data}.
//    - addr = InRow*IMG_W + InCol, computed at full width, then truncated to ADDR_W.
//    - data = InGrad.
//  - Full FIFO: a push is accepted if a pop happens in the same cycle. Otherwise the sample is
//    dropped and Overflow is set; Overflow holds until Clear or Reset.
//  - Empty FIFO: OutValid=0, and OutAddr/OutData hold their last values.
//  - Output: head entry is presented registered.
//    - Beat completes on OutValid && OutReady.
//    - OutAddr/OutData are stable while OutValid=1 && OutReady=0.
//    - Latency: sample accepted at edge N -> OutValid=1 after edge N+1 (empty FIFO, OutReady=1).
//    - Throughput: 1 beat/cycle.
//  - Pointers: wrap modulo DEPTH; count is 0..DEPTH, so full and empty are distinguished.
//  - Reset mid-frame: everything is discarded immediately and the FSM returns to IDLE.
// CONFIGURATION
//  SOBEL_EDGE_PACK_EN defined:
//  - Data is packed Dop bits: 8 consecutive accepted pixels per byte.
//  - The first pixel goes to bit0.
//  - One FIFO push per completed byte.
//  - addr = byte index 0,1,2,... counted from 0 at IDLE.
//  - Entering FLUSH with a partial byte pushes it zero-padded (extra cycle if the FIFO is full).
//  - Packed bytes are subject to the same overflow rule.
//  Undefined:
//  - One byte (InGrad) per pixel at the pixel address.
//  - Pack logic is absent.
// TESTING
//  1 Reset: OutValid=0, FrameDone=0, Overflow=0. Then Row=2, Col=5, Grad=0x7F, OutReady=1
//    -> one beat: OutAddr=133, OutData=0x7F, one cycle after acceptance.
//  2 Backpressure: OutReady=0 with 16 accepted samples -> no Overflow. 17th -> Overflow=1, sample
//    dropped. OutReady=1 -> exactly 16 beats in order, each held stable while stalled.
//  3 Full FIFO with concurrent pop: push and pop in the same cycle -> sample accepted, count stays
//    16, Overflow stays 0.
//  4 Frame end: 4x4 frame, InEnd with the last pixel -> 16 beats, then FrameDone=1. Later
//    InValid is ignored. Clear -> IDLE, FrameDone=0.
//  5 Reset mid-frame: Reset after 5 accepted, 2 emitted -> OutValid=0 immediately, no stale beats
//    afterwards.
//  6 SOBEL_EDGE_PACK_EN: Dop 1,0,1,1,0,0,0,1,1,1 then InEnd
//    -> beats (0,0x8D) and (1,0x03), then FrameDone=1.

Source files
------------

// File: rtl/sobel_result_writer.sv
// sobel_result_writer
//   Final stage of the Sobel datapath. Captures per-pixel results when the window loader
//   flags them valid, buffers them in a FIFO and emits address/data write beats to the
//   output frame memory over a valid/ready handshake. FrameDone rises once the last pixel
//   of the frame has been written out.
//
//   Optional build macro SOBEL_EDGE_PACK_EN: instead of one gradient byte per pixel, the
//   thresholded edge bits (InDop) are packed 8 per byte, first pixel in bit0, and written
//   to consecutive byte addresses 0,1,2,...
//
// Ports
//   Clk, Reset            clock, asynchronous active-high reset
//   InValid, InEnd        result valid / last pixel of frame
//   InGrad, InDop         gradient magnitude, thresholded edge bit
//   InRow, InCol          pixel coordinates
//   Clear                 DONE -> IDLE, clears Overflow (ignored outside DONE)
//   OutValid, OutReady    write beat handshake
//   OutAddr, OutData      write beat payload, held while stalled
//   Overflow              sticky: a sample was dropped on a full FIFO
//   FrameDone             high while the frame is complete
module sobel_result_writer #(
    parameter int unsigned IMG_W  = 64,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 12
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              InValid,
    input  logic              InEnd,
    input  logic [7:0]        InGrad,
    input  logic              InDop,
    input  logic [7:0]        InRow,
    input  logic [7:0]        InCol,
    input  logic              Clear,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [ADDR_W-1:0] OutAddr,
    output logic [7:0]        OutData,
    output logic              Overflow,
    output logic              FrameDone
);

    localparam int unsigned PtrW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW   = PtrW + 1;
    localparam int unsigned EntryW = ADDR_W + 8;

    typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_t;

    state_t stateQ, stateD;

    logic [EntryW-1:0] mem [DEPTH];
    logic [PtrW-1:0]   wrPtrQ, rdPtrQ;
    logic [CntW-1:0]   memCountQ;
    logic              outValidQ;
    logic [ADDR_W-1:0] outAddrQ;
    logic [7:0]        outDataQ;
    logic              overflowQ;

    logic              accepting, beat, load, full, canPush;
    logic              pushReq, push, dropEn, flushBusy, endNow;
    logic [EntryW-1:0] pushEntry;

    // The output register counts as one FIFO slot, so DEPTH results can be held in total.
    assign accepting = InValid && (stateQ == StIdle || stateQ == StRun);
    assign beat      = outValidQ && OutReady;
    assign load      = (memCountQ != '0) && (!outValidQ || OutReady);
    assign full      = (memCountQ + CntW'(outValidQ)) == CntW'(DEPTH);
    assign canPush   = !full || beat;
    assign push      = pushReq && canPush;
    // A single-pixel frame (InEnd with the first sample) goes straight to FLUSH.
    assign endNow    = InEnd && (stateQ == StRun || (stateQ == StIdle && InValid));

`ifdef SOBEL_EDGE_PACK_EN
    logic [7:0]        packBitsQ, packBitsD, withBit;
    logic [2:0]        packCntQ, packCntD;
    logic [ADDR_W-1:0] byteIdxQ, byteIdxD;
    logic              partialQ, partialD;
    logic              unusedPack;

    assign unusedPack = ^{InGrad, InRow, InCol};
    assign withBit    = packBitsQ | (8'(InDop) << packCntQ);
    assign flushBusy  = partialQ;

    always_comb begin
        packBitsD = packBitsQ;
        packCntD  = packCntQ;
        byteIdxD  = byteIdxQ;
        partialD  = partialQ;
        pushReq   = 1'b0;
        dropEn    = 1'b0;
        pushEntry = {byteIdxQ, packBitsQ};
        if (stateQ == StFlush) begin
            // Zero-padded tail byte waits for space rather than being dropped.
            pushReq = partialQ;
            if (push) begin
                partialD  = 1'b0;
                packBitsD = '0;
                packCntD  = '0;
                byteIdxD  = byteIdxQ + ADDR_W'(1);
            end
        end else if (accepting) begin
            if (packCntQ == 3'd7) begin
                pushReq   = 1'b1;
                pushEntry = {byteIdxQ, withBit};
                dropEn    = !canPush;
                packBitsD = '0;
                packCntD  = '0;
                byteIdxD  = byteIdxQ + ADDR_W'(1);
            end else begin
                packBitsD = withBit;
                packCntD  = packCntQ + 3'd1;
            end
        end
        if (endNow) begin
            partialD = (packCntD != 3'd0);
        end
        if (stateQ == StDone && Clear) begin
            packBitsD = '0;
            packCntD  = '0;
            byteIdxD  = '0;
            partialD  = 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            packBitsQ <= '0;
            packCntQ  <= '0;
            byteIdxQ  <= '0;
            partialQ  <= 1'b0;
        end else begin
            packBitsQ <= packBitsD;
            packCntQ  <= packCntD;
            byteIdxQ  <= byteIdxD;
            partialQ  <= partialD;
        end
    end
`else
    logic [31:0] addrFull;
    logic        unusedPack;

    // Full-width address, truncated to ADDR_W (ADDR_W is assumed to be below 32).
    assign addrFull   = 32'(InRow) * IMG_W + 32'(InCol);
    assign unusedPack = ^{InDop, addrFull[31:ADDR_W]};
    assign flushBusy  = 1'b0;
    assign pushReq    = accepting;
    assign dropEn     = accepting && !canPush;
    assign pushEntry  = {addrFull[ADDR_W-1:0], InGrad};
`endif

    always_comb begin
        stateD = stateQ;
        case (stateQ)
            StIdle:  if (endNow) stateD = StFlush;
                     else if (InValid) stateD = StRun;
            StRun:   if (endNow) stateD = StFlush;
            StFlush: if (memCountQ == '0 && !outValidQ && !flushBusy) stateD = StDone;
            StDone:  if (Clear) stateD = StIdle;
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            mem[wrPtrQ] <= pushEntry;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            stateQ    <= StIdle;
            wrPtrQ    <= '0;
            rdPtrQ    <= '0;
            memCountQ <= '0;
            outValidQ <= 1'b0;
            outAddrQ  <= '0;
            outDataQ  <= '0;
            overflowQ <= 1'b0;
        end else begin
            stateQ    <= stateD;
            memCountQ <= memCountQ + CntW'(push) - CntW'(load);
            if (push) wrPtrQ <= wrPtrQ + PtrW'(1);
            if (load) rdPtrQ <= rdPtrQ + PtrW'(1);
            if (load) begin
                outValidQ <= 1'b1;
                outAddrQ  <= mem[rdPtrQ][EntryW-1:8];
                outDataQ  <= mem[rdPtrQ][7:0];
            end else if (beat) begin
                outValidQ <= 1'b0;
            end
            if (stateQ == StDone && Clear) overflowQ <= 1'b0;
            else if (dropEn)               overflowQ <= 1'b1;
        end
    end

    assign OutValid  = outValidQ;
    assign OutAddr   = outAddrQ;
    assign OutData   = outDataQ;
    assign Overflow  = overflowQ;
    assign FrameDone = (stateQ == StDone);

endmodule

// File: tb/tb_sobel_result_writer.sv
module tb_sobel_result_writer;

    logic        Clk = 1'b0;
    logic        Reset, InValid, InEnd, InDop, Clear, OutReady;
    logic [7:0]  InGrad, InRow, InCol;
    logic        OutValid, Overflow, FrameDone;
    logic [11:0] OutAddr;
    logic [7:0]  OutData;

    int checks = 0;
    int errors = 0;

    sobel_result_writer #(.IMG_W(64), .DEPTH(16), .ADDR_W(12)) dut (
        .Clk(Clk), .Reset(Reset), .InValid(InValid), .InEnd(InEnd), .InGrad(InGrad),
        .InDop(InDop), .InRow(InRow), .InCol(InCol), .Clear(Clear), .OutValid(OutValid),
        .OutReady(OutReady), .OutAddr(OutAddr), .OutData(OutData), .Overflow(Overflow),
        .FrameDone(FrameDone)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idleIn();
        InValid = 1'b0; InEnd = 1'b0; InGrad = '0; InDop = 1'b0;
        InRow = '0; InCol = '0; Clear = 1'b0;
    endtask

    task automatic pix(input logic [7:0] row, input logic [7:0] col, input logic [7:0] grad,
                       input logic dop, input logic endf);
        InValid = 1'b1; InEnd = endf; InRow = row; InCol = col; InGrad = grad; InDop = dop;
    endtask

    task automatic doReset();
        idleIn();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
    endtask

    task automatic waitDone(input string tag);
        for (int i = 0; i < 10 && !FrameDone; i++) step();
        chk(tag, FrameDone, 1);
    endtask

    logic [9:0] dops;

    initial begin
        OutReady = 1'b0;
        idleIn();
        Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;
        chk("rst_valid", OutValid, 0);
        chk("rst_done", FrameDone, 0);
        chk("rst_ovf", Overflow, 0);
        chk("rst_addr", OutAddr, 0);
        chk("rst_data", OutData, 0);

`ifndef SOBEL_EDGE_PACK_EN
        // Single pixel latency and address
        OutReady = 1'b1;
        pix(8'd2, 8'd5, 8'h7F, 1'b0, 1'b0);
        step();
        idleIn();
        chk("t1_not_yet", OutValid, 0);
        step();
        chk("t1_valid", OutValid, 1);
        chk("t1_addr", OutAddr, 133);
        chk("t1_data", OutData, 8'h7F);
        step();
        chk("t1_gone", OutValid, 0);

        // Backpressure: 16 fit, 17th dropped
        doReset();
        OutReady = 1'b0;
        for (int i = 0; i < 16; i++) begin
            pix(8'd0, 8'(i), 8'(i + 1), 1'b0, 1'b0);
            step();
        end
        idleIn();
        chk("t2_no_ovf", Overflow, 0);
        chk("t2_head_valid", OutValid, 1);
        pix(8'd0, 8'd16, 8'h99, 1'b0, 1'b0);
        step();
        idleIn();
        chk("t2_ovf", Overflow, 1);
        step();
        chk("t2_stall_addr", OutAddr, 0);
        chk("t2_stall_data", OutData, 1);
        OutReady = 1'b1;
        for (int k = 0; k < 16; k++) begin
            chk("t2_beat_valid", OutValid, 1);
            chk("t2_beat_addr", OutAddr, k);
            chk("t2_beat_data", OutData, k + 1);
            if (k == 8) begin
                OutReady = 1'b0;
                step();
                chk("t2_hold_addr", OutAddr, 8);
                chk("t2_hold_data", OutData, 9);
                OutReady = 1'b1;
            end
            step();
        end
        chk("t2_drained", OutValid, 0);
        chk("t2_ovf_sticky", Overflow, 1);

        // Full FIFO with concurrent pop
        doReset();
        OutReady = 1'b0;
        for (int i = 0; i < 16; i++) begin
            pix(8'd0, 8'(i), 8'(8'h20 + i), 1'b0, 1'b0);
            step();
        end
        pix(8'd0, 8'd16, 8'h30, 1'b0, 1'b0);
        OutReady = 1'b1;
        step();
        idleIn();
        OutReady = 1'b0;
        chk("t3_no_ovf", Overflow, 0);
        chk("t3_head_addr", OutAddr, 1);
        pix(8'd0, 8'd17, 8'h31, 1'b0, 1'b0);
        step();
        idleIn();
        chk("t3_still_full", Overflow, 1);
        OutReady = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            chk("t3_beat_addr", OutAddr, k);
            chk("t3_beat_data", OutData, 8'h20 + k);
            step();
        end
        chk("t3_drained", OutValid, 0);

        // 4x4 frame end
        doReset();
        OutReady = 1'b1;
        for (int t = 0; t < 18; t++) begin
            if (t < 16) pix(8'(t / 4), 8'(t % 4), 8'(8'h40 + t), 1'b0, t == 15);
            else idleIn();
            if (t >= 2) begin
                chk("t4_valid", OutValid, 1);
                chk("t4_addr", OutAddr, ((t - 2) / 4) * 64 + (t - 2) % 4);
                chk("t4_data", OutData, 8'h40 + t - 2);
                chk("t4_not_done", FrameDone, 0);
            end
            step();
        end
        waitDone("t4_done");
        pix(8'd1, 8'd1, 8'hEE, 1'b0, 1'b0);
        step();
        step();
        idleIn();
        chk("t4_ignored", OutValid, 0);
        chk("t4_done_held", FrameDone, 1);
        Clear = 1'b1;
        step();
        Clear = 1'b0;
        chk("t4_cleared", FrameDone, 0);
        pix(8'd3, 8'd3, 8'h55, 1'b0, 1'b0);
        step();
        idleIn();
        step();
        chk("t4_idle_valid", OutValid, 1);
        chk("t4_idle_addr", OutAddr, 195);
        chk("t4_idle_data", OutData, 8'h55);

        // Reset mid-frame
        doReset();
        OutReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pix(8'd1, 8'(i), 8'(8'h60 + i), 1'b0, 1'b0);
            step();
        end
        idleIn();
        OutReady = 1'b1;
        step();
        step();
        chk("t5_third_head", OutAddr, 66);
        Reset = 1'b1;
        #1;
        chk("t5_async_valid", OutValid, 0);
        chk("t5_async_done", FrameDone, 0);
        step();
        Reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("t5_no_stale", OutValid, 0);
        end
`else
        // Packed edge bits: 1,0,1,1,0,0,0,1 | 1,1 -> 0x8D, 0x03
        doReset();
        OutReady = 1'b0;
        dops = 10'b11_1000_1101;
        for (int i = 0; i < 10; i++) begin
            pix(8'd0, 8'(i), 8'h00, dops[i], i == 9);
            step();
        end
        idleIn();
        step();
        chk("p_not_done", FrameDone, 0);
        chk("p_b0_valid", OutValid, 1);
        chk("p_b0_addr", OutAddr, 0);
        chk("p_b0_data", OutData, 8'h8D);
        OutReady = 1'b1;
        step();
        chk("p_b1_valid", OutValid, 1);
        chk("p_b1_addr", OutAddr, 1);
        chk("p_b1_data", OutData, 8'h03);
        step();
        chk("p_drained", OutValid, 0);
        waitDone("p_done");
        chk("p_no_ovf", Overflow, 0);
        Clear = 1'b1;
        step();
        Clear = 1'b0;
        chk("p_cleared", FrameDone, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
